// File: rtl/uart_alu_ctrl_if.sv
// Signal bundle between the command sequencer and its UART receiver, ALU and
// UART transmitter. The sequencer connects through the master modport.
`timescale 1ns/1ps

interface uart_alu_ctrl_if #(
    parameter int DATA_BITS = 8,
    parameter int OP_BITS   = 6
);
    // Handshakes are single-cycle pulses with no back-pressure: i_rx_done marks
    // i_rx_data valid for that one cycle, o_tx_start requests one send and
    // o_tx_data holds until the transmitter answers with a one-cycle i_tx_done.
    logic                 i_tick;
    logic                 i_rx_done;
    logic [DATA_BITS-1:0] i_rx_data;
    logic [DATA_BITS-1:0] i_alu_result;
    logic                 i_tx_done;
    logic [DATA_BITS-1:0] o_data_a;
    logic [DATA_BITS-1:0] o_data_b;
    logic [OP_BITS-1:0]   o_op;
    logic                 o_tx_start;
    logic [DATA_BITS-1:0] o_tx_data;
    logic                 o_busy;
    logic                 o_timeout;
    logic [5:0]           o_state;

    modport master (
        input  i_tick, i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        output o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy,
               o_timeout, o_state
    );

    modport slave (
        output i_tick, i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        input  o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy,
               o_timeout, o_state
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Command sequencer: gathers operand A, operand B and opcode from the UART,
// runs them through the ALU and sends the one-byte result back out.
`timescale 1ns/1ps

module uart_alu_ctrl #(
    parameter int DATA_BITS     = 8,
    parameter int OP_BITS       = 6,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic               i_clock,
    input  logic               i_reset,
    uart_alu_ctrl_if.master    bus
);
    localparam int CNT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [5:0] {
        S_GET_A   = 6'b000001,
        S_GET_B   = 6'b000010,
        S_GET_OP  = 6'b000100,
        S_EXEC    = 6'b001000,
        S_SEND    = 6'b010000,
        S_WAIT_TX = 6'b100000
    } state_e;

    state_e               state_q,   state_d;
    logic [DATA_BITS-1:0] data_a_q,  data_a_d;
    logic [DATA_BITS-1:0] data_b_q,  data_b_d;
    logic [OP_BITS-1:0]   op_q,      op_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 terminal_tick;

    always_comb begin
        state_d       = state_q;
        data_a_d      = data_a_q;
        data_b_d      = data_b_q;
        op_d          = op_q;
        tx_data_d     = tx_data_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
        terminal_tick = bus.i_tick && (cnt_q == CNT_MAX);

        case (state_q)
            S_GET_A: begin
                if (bus.i_rx_done) begin
                    data_a_d = bus.i_rx_data;
                    cnt_d    = '0;
                    state_d  = S_GET_B;
                end
            end
            S_GET_B: begin
                // A byte arriving on the terminal tick still counts.
                if (bus.i_rx_done) begin
                    data_b_d = bus.i_rx_data;
                    cnt_d    = '0;
                    state_d  = S_GET_OP;
                end else if (terminal_tick) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_GET_A;
                end else if (bus.i_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GET_OP: begin
                if (bus.i_rx_done) begin
                    op_d    = bus.i_rx_data[OP_BITS-1:0];
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else if (terminal_tick) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_GET_A;
                end else if (bus.i_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                // Operands have been registered for a full cycle, so the ALU has settled.
                tx_data_d = bus.i_alu_result;
                state_d   = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    state_d = S_GET_A;
                end
            end
            default: begin
                data_a_d  = '0;
                data_b_d  = '0;
                op_d      = '0;
                tx_data_d = '0;
                cnt_d     = '0;
                state_d   = S_GET_A;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= S_GET_A;
            data_a_q  <= '0;
            data_b_q  <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            op_q      <= op_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_data_a   = data_a_q;
    assign bus.o_data_b   = data_b_q;
    assign bus.o_op       = op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = (state_q == S_SEND);
    assign bus.o_busy     = (state_q != S_GET_A);
    assign bus.o_timeout  = timeout_q;
    assign bus.o_state    = state_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed command sequences against a command-level
// model, compared on every falling edge, plus literal spot checks.
`timescale 1ns/1ps

module tb_uart_alu_ctrl;
    localparam int DATA_BITS     = 8;
    localparam int OP_BITS       = 6;
    localparam int TIMEOUT_TICKS = 4096;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   timeout_seen;

    uart_alu_ctrl_if #(.DATA_BITS(DATA_BITS), .OP_BITS(OP_BITS)) bus();

    uart_alu_ctrl #(
        .DATA_BITS(DATA_BITS), .OP_BITS(OP_BITS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus.master)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_fn(bus.o_data_a, bus.o_data_b, bus.o_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // command-level model: bytes collected so far, post-opcode stage, tick gap
    int         m_bytes;
    int         m_stage;
    int         m_gap;
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    logic       m_timeout;
    logic       model_on;

    task automatic model_step();
        if (rst) begin
            m_bytes = 0; m_stage = 0; m_gap = 0;
            m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
            m_timeout = 1'b0;
            model_on = 1'b1;
        end else begin
            m_timeout = 1'b0;
            case (m_stage)
                0: begin
                    if (bus.i_rx_done) begin
                        if (m_bytes == 0) m_a = bus.i_rx_data;
                        else if (m_bytes == 1) m_b = bus.i_rx_data;
                        else m_op = bus.i_rx_data[5:0];
                        m_gap = 0;
                        if (m_bytes == 2) begin
                            m_bytes = 0;
                            m_stage = 1;
                        end else begin
                            m_bytes++;
                        end
                    end else if (m_bytes != 0 && bus.i_tick) begin
                        m_gap++;
                        if (m_gap == TIMEOUT_TICKS) begin
                            m_timeout = 1'b1;
                            m_bytes = 0;
                            m_gap = 0;
                        end
                    end
                end
                1: begin
                    m_tx = alu_fn(m_a, m_b, m_op);
                    m_stage = 2;
                end
                2: m_stage = 3;
                default: if (bus.i_tx_done) m_stage = 0;
            endcase
        end
    endtask

    initial model_on = 1'b0;
    always @(posedge clk) model_step();

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (bus.o_timeout === 1'b1) timeout_seen++;
        if (model_on) begin
            check("busy",     {31'd0, bus.o_busy},     {31'd0, (m_stage != 0 || m_bytes != 0)});
            check("tx_start", {31'd0, bus.o_tx_start}, {31'd0, (m_stage == 2)});
            check("timeout",  {31'd0, bus.o_timeout},  {31'd0, m_timeout});
            check("data_a",   {24'd0, bus.o_data_a},   {24'd0, m_a});
            check("data_b",   {24'd0, bus.o_data_b},   {24'd0, m_b});
            check("op",       {26'd0, bus.o_op},       {26'd0, m_op});
            check("tx_data",  {24'd0, bus.o_tx_data},  {24'd0, m_tx});
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input logic with_tick);
        @(posedge clk); #1;
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = b;
        bus.i_tick    = with_tick;
        @(posedge clk); #1;
        bus.i_rx_done = 1'b0;
        bus.i_tick    = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 bus.i_tick = 1'b1;
            @(posedge clk); #1 bus.i_tick = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // called right after the opcode byte has been sampled
    task automatic finish_cmd(input string tag, input logic [7:0] exp, input logic inject);
        @(negedge clk);
        check({tag, "_exec_no_start"}, {31'd0, bus.o_tx_start}, 32'd0);
        @(negedge clk);
        check({tag, "_send_start"}, {31'd0, bus.o_tx_start}, 32'd1);
        check({tag, "_tx_data"}, {24'd0, bus.o_tx_data}, {24'd0, exp});
        if (inject) begin
            @(posedge clk); #1;
            bus.i_rx_done = 1'b1;
            bus.i_rx_data = 8'h55;
            @(posedge clk); #1 bus.i_rx_done = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 bus.i_tx_done = 1'b1;
        @(posedge clk); #1 bus.i_tx_done = 1'b0;
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, bus.o_busy}, 32'd0);
        check({tag, "_tx_hold"}, {24'd0, bus.o_tx_data}, {24'd0, exp});
    endtask

    initial begin
        int ts;
        checks = 0; failures = 0; timeout_seen = 0;
        rst = 1'b1;
        bus.i_tick = 1'b0; bus.i_rx_done = 1'b0; bus.i_rx_data = 8'h00; bus.i_tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy",     {31'd0, bus.o_busy},     32'd0);
        check("rst_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
        check("rst_timeout",  {31'd0, bus.o_timeout},  32'd0);
        check("rst_data_a",   {24'd0, bus.o_data_a},   32'd0);
        check("rst_tx_data",  {24'd0, bus.o_tx_data},  32'd0);

        // 1: basic ADD
        send_byte(8'h05, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h20, 1'b0);
        check("t1_op", {26'd0, bus.o_op}, 32'h20);
        finish_cmd("t1", 8'h08, 1'b0);

        // 2: timeout after one byte, then wrapping add
        send_byte(8'h11, 1'b0);
        ticks(TIMEOUT_TICKS - 1);
        @(negedge clk);
        check("t2_pre_timeout", {31'd0, bus.o_timeout}, 32'd0);
        check("t2_pre_busy",    {31'd0, bus.o_busy},    32'd1);
        ticks(1);
        @(negedge clk);
        check("t2_timeout",     {31'd0, bus.o_timeout}, 32'd1);
        check("t2_back_idle",   {31'd0, bus.o_busy},    32'd0);
        check("t2_a_retained",  {24'd0, bus.o_data_a},  32'h11);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        finish_cmd("t2", 8'h00, 1'b0);

        // 3: opcode byte lands on the terminal tick
        send_byte(8'h30, 1'b0);
        send_byte(8'h0F, 1'b0);
        ticks(TIMEOUT_TICKS - 1);
        ts = timeout_seen;
        send_byte(8'h24, 1'b1);
        check("t3_no_timeout", timeout_seen - ts, 32'd0);
        finish_cmd("t3", 8'h00, 1'b0);

        // 4: stray byte during WAIT_TX is dropped
        send_byte(8'h07, 1'b0);
        send_byte(8'h09, 1'b0);
        send_byte(8'h20, 1'b0);
        finish_cmd("t4a", 8'h10, 1'b1);
        check("t4_a_kept", {24'd0, bus.o_data_a}, 32'h07);
        send_byte(8'h02, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        finish_cmd("t4b", 8'h04, 1'b0);

        // 5: reset in WAIT_TX and in GET_B
        send_byte(8'h0C, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t5_send", {31'd0, bus.o_tx_start}, 32'd1);
        pulse_reset();
        @(negedge clk);
        check("t5_rst_busy",    {31'd0, bus.o_busy},    32'd0);
        check("t5_rst_tx_data", {24'd0, bus.o_tx_data}, 32'd0);
        check("t5_rst_data_a",  {24'd0, bus.o_data_a},  32'd0);
        check("t5_rst_op",      {26'd0, bus.o_op},      32'd0);
        repeat (4) @(posedge clk);
        send_byte(8'h09, 1'b0);
        pulse_reset();
        @(negedge clk);
        check("t5_rst2_busy",   {31'd0, bus.o_busy},    32'd0);
        check("t5_rst2_data_a", {24'd0, bus.o_data_a},  32'd0);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h22, 1'b0);
        finish_cmd("t5", 8'h05, 1'b0);

        // 6: long idle in GET_A never times out
        ts = timeout_seen;
        ticks(10000);
        @(negedge clk);
        check("t6_no_timeout", timeout_seen - ts, 32'd0);
        check("t6_busy",       {31'd0, bus.o_busy}, 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Command sequencer between the UART receiver, a combinational ALU and the UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents them to the ALU, captures the result and hands it to the transmitter for one byte send.
- Aborts a partial command if the gap between received bytes exceeds a baud-tick timeout.

Parameters:
- DATA_BITS, 8, width of every UART byte, operand and result.
- OP_BITS, 6, width of the ALU opcode; taken from the low bits of the third byte.
- TIMEOUT_TICKS, 4096, number of i_tick pulses allowed between consecutive bytes of one command.

Ports:
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  baud oversampling tick (16x), one cycle wide.
- i_rx_done  in  1  one-cycle pulse: a received byte is valid.
- i_rx_data  in  DATA_BITS  received byte; sampled only when i_rx_done=1.
- i_alu_result  in  DATA_BITS  combinational ALU output.
- i_tx_done  in  1  one-cycle pulse: transmitter finished its byte.
- o_data_a  out  DATA_BITS  registered operand A to ALU.
- o_data_b  out  DATA_BITS  registered operand B to ALU.
- o_op  out  OP_BITS  registered opcode to ALU.
- o_tx_start  out  1  one-cycle pulse requesting a transmit.
- o_tx_data  out  DATA_BITS  registered byte to transmit; stable from o_tx_start until i_tx_done.
- o_busy  out  1  high in every state except GET_A.
- o_timeout  out  1  one-cycle pulse when a partial command is aborted.

Behaviour:
- Reset (synchronous, i_reset=1 at a clock edge):
  - State goes to GET_A.
  - All data outputs and the timeout counter clear to 0.
  - o_tx_start, o_timeout and o_busy go to 0.
  - Reset has priority over all events, including mid-command and mid-transmit.
- State GET_A:
  - On i_rx_done: o_data_a <= i_rx_data, clear timeout counter, go to GET_B.
  - The timeout counter does not run in GET_A.
- State GET_B:
  - On i_rx_done: o_data_b <= i_rx_data, clear counter, go to GET_OP.
- State GET_OP:
  - On i_rx_done: o_op <= i_rx_data[OP_BITS-1:0], go to EXEC.
- Timeout (GET_B and GET_OP only):
  - Counter increments on each i_tick.
  - When the counter equals TIMEOUT_TICKS-1 and i_tick=1, pulse o_timeout, clear the counter and go to GET_A.
  - o_data_a, o_data_b and o_op retain their values.
  - If i_rx_done and the terminal tick occur in the same cycle, the byte wins; no timeout.
  - Counter width is clog2(TIMEOUT_TICKS); it never wraps.
- State EXEC (exactly 1 cycle):
  - o_tx_data <= i_alu_result, go to SEND.
  - This allows one cycle for the ALU to settle on the registered operands.
- State SEND (exactly 1 cycle):
  - o_tx_start=1, go to WAIT_TX.
- State WAIT_TX:
  - On i_tx_done: go to GET_A.
  - No timeout in this state.
- Bytes arriving outside GET_* states:
  - i_rx_done in EXEC, SEND or WAIT_TX is ignored (dropped).
- Latency:
  - The opcode's i_rx_done cycle is edge 0; EXEC is entered at edge 1.
  - o_tx_start is high during the cycle after edge 2.
- Encoding:
  - One-hot, 6 states.
  - Any illegal encoding returns to GET_A with outputs cleared.

Test Plan:
1. Reset, then bytes 0x05, 0x03, 0x20 with ALU model ADD (0x20) -> o_op=0x20, o_tx_start pulses once 2 cycles after the third i_rx_done, o_tx_data=0x08, o_busy returns to 0 after i_tx_done.
2. Byte 0x11, then 4096 ticks with no i_rx_done -> o_timeout pulses exactly on the 4096th tick, state returns to GET_A; next three bytes 0xFF, 0x01, 0x20 -> o_tx_data=0x00 (8-bit wrap).
3. In GET_OP, i_rx_done and the terminal tick in the same cycle -> no o_timeout, command executes normally.
4. Extra byte 0x55 injected during WAIT_TX -> ignored; next command 0x02, 0x02, 0x20 yields o_tx_data=0x04.
5. i_reset asserted in WAIT_TX and again in GET_B -> outputs 0 on the next edge, no o_tx_start, following full command executes correctly.
6. Idle in GET_A for 10000 ticks -> no o_timeout, o_busy stays 0.
